// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game sequencer.
// Holds the FSM encoding, color codes, LFSR constants and button decode helper.
package genius_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_ECHO,
    ST_GAP,
    ST_FAIL,
    ST_WIN
  } state_e;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic       vld;
    logic [1:0] code;
  } press_t;

  function automatic press_t onehot_to_code(input logic [3:0] oh);
    press_t r;
    r.vld  = 1'b1;
    r.code = GREEN;
    case (oh)
      4'b0001: r.code = GREEN;
      4'b0010: r.code = RED;
      4'b0100: r.code = YELLOW;
      4'b1000: r.code = BLUE;
      default: r.vld  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed on reset.
module genius_lfsr16
  import genius_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= {^(q_q & LFSR_TAPS), q_q[15:1]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/genius_seq_ctrl.sv
// Genius game sequencer: grows a random color sequence, plays it back as timed
// lamp flashes, then checks the player's presses step by step.
module genius_seq_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int ON_CYC      = 25000000,
  parameter int OFF_CYC     = 12500000,
  parameter int TIMEOUT_CYC = 250000000,
  parameter int CNT_W       = 28
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  output logic       lamp_on,
  output logic [1:0] lamp_color,
  output logic [6:0] level,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [6:0]       len_q, len_d;
  logic [6:0]       idx_q, idx_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       col_q, col_d;
  logic             seq_we;
  logic [1:0]       seq_q [MAX_LEN];
  logic [15:0]      lfsr_q;
  logic             lfsr_unused;
  press_t           press;
  logic [1:0]       cur_col;
  logic             last_step;

  logic             lamp_on_q, busy_q, game_over_q, win_q;
  logic [1:0]       lamp_color_q;

  genius_lfsr16 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .q        (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:2];
  assign press       = onehot_to_code(btn);
  assign cur_col     = seq_q[idx_q[IDX_W-1:0]];
  assign last_step   = (idx_q == len_q - 7'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    col_d   = col_q;
    seq_we  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAIL, ST_WIN: begin
        if (start) begin
          state_d = ST_ADD;
          len_d   = 7'd0;
        end
      end
      ST_ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + 7'd1;
        idx_d   = 7'd0;
        timer_d = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (last_step) begin
            idx_d   = 7'd0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = ST_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_IN: begin
        // Any press outranks a timeout landing on the same cycle.
        if (btn != 4'b0000) begin
          if (press.vld && (press.code == cur_col)) begin
            col_d   = press.code;
            timer_d = '0;
            state_d = ST_ECHO;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = ST_FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ECHO: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (!last_step) begin
            idx_d   = idx_q + 7'd1;
            state_d = ST_WAIT_IN;
          end else if (len_q == 7'(MAX_LEN)) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_ADD;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= 7'd0;
      idx_q   <= 7'd0;
      timer_q <= '0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      col_q   <= col_d;
    end
  end

  // Sequence storage is never cleared; only entries below len are meaningful.
  always_ff @(posedge CLOCK_50) begin
    if (seq_we) begin
      seq_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
    end
  end

  // Outputs are registered decodes of the current state, one cycle behind it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lamp_on_q    <= 1'b0;
      lamp_color_q <= 2'd0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      lamp_on_q   <= (state_q == ST_SHOW_ON) || (state_q == ST_ECHO);
      busy_q      <= (state_q == ST_SHOW_ON) || (state_q == ST_SHOW_OFF);
      game_over_q <= (state_q == ST_FAIL);
      win_q       <= (state_q == ST_WIN);
      if (state_q == ST_SHOW_ON) begin
        lamp_color_q <= cur_col;
      end else if (state_q == ST_ECHO) begin
        lamp_color_q <= col_q;
      end
    end
  end

  assign lamp_on    = lamp_on_q;
  assign lamp_color = lamp_color_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign win        = win_q;
  assign level      = len_q;

endmodule

// File: doc/genius_seq_ctrl.md
Name: genius_seq_ctrl

Overview:
- Game-sequencing controller for the FPGA Genius (Simon) design, sitting between the debounced button inputs and the VGA renderer.
- Builds a growing random color sequence and plays it back as timed lamp flashes.
- Checks player entry step by step, and advances level, signals failure, or signals victory.
- The renderer consumes lamp_on/lamp_color to highlight one of four quadrants.

Parameters:
- MAX_LEN, 16, maximum sequence length (winning length); 2..64.
- ON_CYC, 25000000, clock cycles a lamp is lit (0.5 s at 50 MHz).
- OFF_CYC, 12500000, dark gap cycles between flashes.
- TIMEOUT_CYC, 250000000, cycles allowed per player press before failure.
- CNT_W, 28, timer width; must hold max(ON_CYC, OFF_CYC, TIMEOUT_CYC).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new game from IDLE, FAIL or WIN.
- btn  in  4  one-cycle debounced press pulses; bit0 green, bit1 red, bit2 yellow, bit3 blue.
- lamp_on  out  1  quadrant highlight enable.
- lamp_color  out  2  quadrant code (0 green, 1 red, 2 yellow, 3 blue).
- level  out  7  current sequence length.
- busy  out  1  high while playback is running (buttons ignored).
- game_over  out  1  held high in FAIL.
- win  out  1  held high in WIN.

Behaviour:
- Reset: state IDLE; all outputs 0; len=0; idx=0; timer=0; LFSR=16'hACE1. Reset applied mid-game aborts immediately to this state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state, so start timing randomizes the game. New color = lfsr[1:0].
- Sequence storage: MAX_LEN x 2-bit register array. Contents are not cleared; only entries below len are valid.
- IDLE: start -> ADD with len=0.
- ADD (1 cycle): seq[len]<=lfsr[1:0]; len<=len+1; idx<=0; -> SHOW_ON.
- SHOW_ON: lamp_on=1, lamp_color=seq[idx], busy=1, for exactly ON_CYC cycles -> SHOW_OFF.
- SHOW_OFF: lamp_on=0, busy=1, for OFF_CYC cycles.
  - If idx==len-1: idx<=0, timer cleared -> WAIT_IN.
  - Otherwise: idx++ -> SHOW_ON.
- WAIT_IN: timer counts up each cycle. On a btn pulse:
  - Exactly one bit set and its encoding == seq[idx] -> ECHO, with lamp_color = pressed color.
  - Zero-hot is not a press.
  - Multi-hot, or a wrong color -> FAIL.
  - timer reaching TIMEOUT_CYC-1 with no press -> FAIL.
  - A press on the same cycle as the timeout takes priority over the timeout.
- ECHO: lamp_on=1 for ON_CYC cycles, then GAP (lamp off, OFF_CYC cycles). After GAP:
  - idx<len-1: idx++, timer cleared -> WAIT_IN.
  - idx==len-1 and len==MAX_LEN -> WIN.
  - Otherwise -> ADD.
- btn is ignored in every state except WAIT_IN, including presses during ECHO/GAP.
- FAIL: game_over=1, lamp_on=0; level holds the failing length. start -> ADD with len=0, game_over cleared.
- WIN: win=1, lamp_on=0, level=MAX_LEN. start -> ADD with len=0, win cleared.
- start is ignored in ADD, SHOW_ON, SHOW_OFF, WAIT_IN, ECHO and GAP.
- Timing:
  - All outputs are registered.
  - lamp_on rises one cycle after entry to SHOW_ON/ECHO.
  - Flash length is exactly ON_CYC cycles; gap length is exactly OFF_CYC cycles.
- level=len is valid from the cycle after ADD.

Decomposition:
- Shared package genius_pkg:
  - State encoding: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, ECHO, GAP, FAIL, WIN.
  - Color codes GREEN=0, RED=1, YELLOW=2, BLUE=3.
  - LFSR_SEED=16'hACE1 and tap mask.
  - One-hot-to-code function with a valid flag.
- One sub-module: genius_lfsr16 (CLOCK_50, reset, q[15:0]), free-running, reloading the seed on reset.
- The FSM, timer and sequence array stay in genius_seq_ctrl.

Test Plan:
Bench parameters: MAX_LEN=3, ON_CYC=4, OFF_CYC=2, TIMEOUT_CYC=20. The bench runs a golden LFSR model.
- Reset then idle 10 cycles -> all outputs 0, state IDLE; reset asserted during SHOW_ON -> outputs 0 on the next cycle.
- start at cycle k -> level=1 and one flash with lamp_color = model color; lamp_on high exactly 4 cycles; busy falls after the 2-cycle gap.
- Correct press each round through len=3 -> flash counts 1, 2, 3 with matching colors; win=1 after the final GAP; then start -> win=0, level=1.
- In round 2, first press correct, second press wrong -> game_over=1 the next cycle, level=2, lamp_on=0; later btn pulses leave state unchanged.
- No press in WAIT_IN -> game_over=1 exactly 20 cycles after WAIT_IN entry; press on the 20th cycle -> accepted, no failure.
- btn=4'b0011 in WAIT_IN -> FAIL; btn pulse during SHOW_ON/ECHO -> ignored with no state change; start mid-playback -> ignored.
